// File: rtl/ray_plane_dot.sv
// ray_plane_dot
//
// Feeds the fixed-point divider in the ray/plane intersection path. It pops one
// ray/plane record from a show-ahead FIFO. Over three cycles it accumulates
//   numerator   = dot(N, P0 - O)
//   denominator = dot(N, D)
// It then writes the rescaled and saturated pair into the divider's input FIFO.
//
// Ports:
//   clock      rising-edge clock for all state
//   reset      synchronous, active-high; drops any record in flight
//   origin     ray origin O      (element 0 = x, 1 = y, 2 = z), signed Q_BITS fraction
//   dir        ray direction D
//   normal     plane normal N
//   point      point on plane P0
//   in_empty   input FIFO empty; data ports are valid whenever this is low
//   in_rd_en   pop strobe for the input FIFO
//   dividend   dot(N, P0 - O), signed D_WIDTH, Q_BITS fraction
//   divisor    dot(N, D), signed D_WIDTH, Q_BITS fraction
//   out_wr_en  write strobe into the divider input FIFO
//   out_full   divider input FIFO full
module ray_plane_dot #(
  parameter int Q_BITS  = 10,
  parameter int D_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic signed [D_WIDTH-1:0] origin [3],
  input  logic signed [D_WIDTH-1:0] dir    [3],
  input  logic signed [D_WIDTH-1:0] normal [3],
  input  logic signed [D_WIDTH-1:0] point  [3],
  input  logic                      in_empty,
  output logic                      in_rd_en,
  output logic signed [D_WIDTH-1:0] dividend,
  output logic signed [D_WIDTH-1:0] divisor,
  output logic                      out_wr_en,
  input  logic                      out_full
);

  localparam int DELTA_W = D_WIDTH + 1;
  localparam int PNUM_W  = 2 * D_WIDTH + 1;
  localparam int PDEN_W  = 2 * D_WIDTH;
  localparam int ACC_W   = 2 * D_WIDTH + 3;

  // Saturation bounds expressed at accumulator width so the comparison is signed
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t state, state_next;

  logic signed [D_WIDTH-1:0] origin_r [3];
  logic signed [D_WIDTH-1:0] dir_r    [3];
  logic signed [D_WIDTH-1:0] normal_r [3];
  logic signed [D_WIDTH-1:0] point_r  [3];
  logic [1:0]                k;

  logic signed [ACC_W-1:0]   acc_num, acc_den;
  logic signed [ACC_W-1:0]   acc_num_next, acc_den_next;
  logic signed [D_WIDTH-1:0] pk, ok, nk, dk;
  logic signed [DELTA_W-1:0] delta;
  logic signed [PNUM_W-1:0]  prod_num;
  logic signed [PDEN_W-1:0]  prod_den;

  // Arithmetic shift floors toward negative infinity; the result is then
  // clamped into the D_WIDTH signed range.
  function automatic logic signed [D_WIDTH-1:0] shift_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> Q_BITS;
    if (shifted > SAT_MAX)
      return {1'b0, {(D_WIDTH-1){1'b1}}};
    else if (shifted < SAT_MIN)
      return {1'b1, {(D_WIDTH-1){1'b0}}};
    else
      return shifted[D_WIDTH-1:0];
  endfunction

  // Select the component that the MAC works on in this cycle
  always_comb begin
    pk = point_r[2];
    ok = origin_r[2];
    nk = normal_r[2];
    dk = dir_r[2];
    case (k)
      2'd0: begin
        pk = point_r[0];
        ok = origin_r[0];
        nk = normal_r[0];
        dk = dir_r[0];
      end
      2'd1: begin
        pk = point_r[1];
        ok = origin_r[1];
        nk = normal_r[1];
        dk = dir_r[1];
      end
      default: ;
    endcase
  end

  // The difference needs one extra bit so that it cannot wrap.
  // Both factors are sign-extended to the full product width, so the low bits
  // of the product are the exact signed result.
  always_comb begin
    delta        = {pk[D_WIDTH-1], pk} - {ok[D_WIDTH-1], ok};
    prod_num     = $signed({{D_WIDTH{delta[DELTA_W-1]}}, delta}
                           * {{(D_WIDTH+1){nk[D_WIDTH-1]}}, nk});
    prod_den     = $signed({{D_WIDTH{dk[D_WIDTH-1]}}, dk}
                           * {{D_WIDTH{nk[D_WIDTH-1]}}, nk});
    acc_num_next = acc_num + {{2{prod_num[PNUM_W-1]}}, prod_num};
    acc_den_next = acc_den + {{3{prod_den[PDEN_W-1]}}, prod_den};
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Operand capture, accumulation, and result registers. The results load on
  // the last MAC cycle, so they are already stable on entry to S_OUT.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        origin_r[i] <= '0;
        dir_r[i]    <= '0;
        normal_r[i] <= '0;
        point_r[i]  <= '0;
      end
      acc_num  <= '0;
      acc_den  <= '0;
      k        <= 2'd0;
      dividend <= '0;
      divisor  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!in_empty) begin
            origin_r <= origin;
            dir_r    <= dir;
            normal_r <= normal;
            point_r  <= point;
            acc_num  <= '0;
            acc_den  <= '0;
            k        <= 2'd0;
          end
        end
        S_MAC: begin
          acc_num <= acc_num_next;
          acc_den <= acc_den_next;
          k       <= k + 2'd1;
          if (k == 2'd2) begin
            dividend <= shift_sat(acc_num_next);
            divisor  <= shift_sat(acc_den_next);
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and FIFO strobes. The strobes are held low during reset so that
  // nothing is popped or written while the block is being cleared.
  always_comb begin
    state_next = state;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    case (state)
      S_IDLE: begin
        in_rd_en = !in_empty && !reset;
        if (!in_empty)
          state_next = S_MAC;
      end
      S_MAC: begin
        if (k == 2'd2)
          state_next = S_OUT;
      end
      S_OUT: begin
        out_wr_en = !out_full && !reset;
        if (!out_full)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: doc/ray_plane_dot.md
Name: ray_plane_dot

Overview:
- Upstream feeder of the fixed-point divide stage in the ray/plane intersection path.
- Pops one ray/plane record from its input FIFO and computes numerator = dot(N, P0 - O) and denominator = dot(N, D).
- Uses a 3-cycle iterative multiply-accumulate.
- Writes the (dividend, divisor) pair into the divider's input FIFO, where the divider forms t = num/den.

Parameters:
- Q_BITS, 10: fractional bits of all fixed-point operands and results.
- D_WIDTH, 32: signed data width of every scalar operand and result.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- origin  in  3 x D_WIDTH signed  ray origin O; element 0 = x, 1 = y, 2 = z.
- dir  in  3 x D_WIDTH signed  ray direction D.
- normal  in  3 x D_WIDTH signed  plane normal N.
- point  in  3 x D_WIDTH signed  point on plane P0.
- in_empty  in  1  input FIFO empty; when low, the data ports are valid (show-ahead FIFO).
- in_rd_en  out  1  pops one input record.
- dividend  out  D_WIDTH signed  numerator dot(N, P0 - O), Q_BITS fraction.
- divisor  out  D_WIDTH signed  denominator dot(N, D), Q_BITS fraction.
- out_wr_en  out  1  write strobe into the divider input FIFO.
- out_full  in  1  divider input FIFO full.

Behaviour:
- Reset: state = S_IDLE. in_rd_en = 0, out_wr_en = 0, dividend = 0, divisor = 0, accumulators cleared.
- Reset mid-operation: the in-flight record is discarded and not written. A record already popped is lost; this is accepted behaviour.
- S_IDLE:
  - in_rd_en = !in_empty, combinational, asserted only in S_IDLE.
  - When in_empty = 0: register all 12 operands, clear both accumulators, set k = 0, go to S_MAC.
- S_MAC, one cycle per component, k = 0, 1, 2:
  - delta = point[k] - origin[k], computed in D_WIDTH+1 bits signed.
  - acc_num += delta * normal[k].
  - acc_den += dir[k] * normal[k].
  - Product widths: 2*D_WIDTH+1 for num, 2*D_WIDTH for den. Accumulators are 2*D_WIDTH+3 bits signed; no internal overflow is possible.
  - After k = 2, go to S_OUT.
- Result formation, registered on entry to S_OUT:
  - Arithmetic right shift of each accumulator by Q_BITS, truncating toward negative infinity.
  - Saturate to D_WIDTH signed: max 2^(D_WIDTH-1)-1, min -2^(D_WIDTH-1).
- S_OUT:
  - out_wr_en = !out_full, combinational.
  - When out_full = 0: write occurs this cycle, go to S_IDLE.
  - While out_full = 1: hold state. dividend and divisor remain stable, and in_rd_en stays 0.
- Latency: pop at cycle 0, MAC at cycles 1-3, write at cycle 4 with no backpressure. Throughput is 1 record per 5 cycles.
- A new pop cannot coincide with a write. The S_OUT to S_IDLE transition costs one cycle; this is accepted.
- Zero denominator: passed through unchanged. Divide-by-zero handling belongs to the divider.
- in_empty toggling outside S_IDLE is ignored.

Test Plan:
- Basic case, Q_BITS = 10, D_WIDTH = 32.
  - Stimulus: O = (0,0,0), D = (0,0,1024), N = (0,0,1024), P0 = (0,0,5120).
  - Response: dividend = 5120, divisor = 1024. in_rd_en pulses at cycle 0 and out_wr_en at cycle 4, each exactly one cycle.
- Negative/mixed case.
  - Stimulus: O = (1024,-2048,512), D = (-1024,0,0), N = (1024,1024,0), P0 = (0,0,0).
  - Response: dividend = 1024, divisor = -1024.
- Saturation.
  - Stimulus: N = (2^30, 2^30, 2^30), P0 = (2^30, 2^30, 2^30), O = (-2^30, -2^30, -2^30), D = (-2^30, -2^30, -2^30).
  - Response: dividend = 0x7FFFFFFF, divisor = 0x80000000.
- Backpressure.
  - Stimulus: out_full = 1 from cycle 3 to cycle 12, with in_empty = 0 throughout.
  - Response: out_wr_en = 0 and outputs stable during that window. Single write at cycle 13, second pop at cycle 14.
- Streaming.
  - Stimulus: 8 back-to-back records with in_empty = 0 and out_full = 0.
  - Response: 8 writes with correct values in input order, spaced exactly 5 cycles apart, and no extra pops.
- Reset mid-MAC.
  - Stimulus: assert reset at cycle 2 of a record.
  - Response: next cycle all outputs are 0 and state is S_IDLE. No write occurs for that record, and the next record is processed correctly.
